// File: rtl/sine_lut_pkg.sv
// Shared constants and elaboration-time table math for the DDS sine LUT.
// The table is built entirely from constant functions and never at run time.
package sine_lut_pkg;

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } quadrant_t;

    localparam real HALF_PI = 1.5707963267948966;

    function automatic int sine_amp(input int dw);
        return (1 << (dw - 1)) - 1;
    endfunction

    function automatic int round_half_away(input real x);
        if (x >= 0.0) begin
            return $rtoi(x + 0.5);
        end
        return -$rtoi(0.5 - x);
    endfunction

    // Taylor series on [0, pi/2]; converges far below one LSB at 16 bits.
    function automatic real sin_first_quad(input real x);
        real term;
        real sum;
        real x2;
        term = x;
        sum  = x;
        x2   = x * x;
        for (int k = 1; k < 12; k++) begin
            term = -term * x2 / real'((2 * k) * (2 * k + 1));
            sum  = sum + term;
        end
        return sum;
    endfunction

    function automatic int sine_entry(input int a, input int dw, input int ld);
        int  n;
        int  q4;
        int  aa;
        int  quad;
        int  i;
        int  k;
        int  r;
        real x;
        n    = 1 << ld;
        q4   = n >> 2;
        aa   = a % n;
        quad = aa / q4;
        i    = aa % q4;
        k    = ((quad & 1) != 0) ? (q4 - i) : i;
        x    = HALF_PI * real'(k) / real'(q4);
        r    = round_half_away(real'(sine_amp(dw)) * sin_first_quad(x));
        return ((quad & 2) != 0) ? -r : r;
    endfunction

endpackage

// File: rtl/sine_quarter_rom.sv
// Combinational quarter-wave ROM holding R[0..Q], Q = 2^(LUT_DEPTH-2).
// Only instantiated when SINE_LUT_QUARTER_WAVE_EN is defined.
module sine_quarter_rom
    import sine_lut_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int LUT_DEPTH  = 8
) (
    input  logic [LUT_DEPTH-2:0]  idx,
    output logic [DATA_WIDTH-1:0] data
);

    localparam int Q = 1 << (LUT_DEPTH - 2);
    localparam logic [LUT_DEPTH-2:0] QMAX = (LUT_DEPTH - 1)'(Q);

    logic [DATA_WIDTH-1:0] rom [0:Q];

    for (genvar g = 0; g <= Q; g++) begin : g_rom
        localparam logic [DATA_WIDTH-1:0] E =
            DATA_WIDTH'(sine_entry(g, DATA_WIDTH, LUT_DEPTH));
        assign rom[g] = E;
    end

    assign data = (idx <= QMAX) ? rom[idx] : '0;

endmodule

// File: rtl/sine_lut.sv
// Registered sine LUT for the DDS tone path; async active-high clear.
// Define SINE_LUT_QUARTER_WAVE_EN to store a quarter wave and mirror/negate.
module sine_lut
    import sine_lut_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int LUT_DEPTH  = 8
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  en,
    input  logic [LUT_DEPTH-1:0]  address,
    output logic [DATA_WIDTH-1:0] value
);

    logic [DATA_WIDTH-1:0] sample;
    logic [DATA_WIDTH-1:0] value_d;
    logic [DATA_WIDTH-1:0] value_q;

`ifdef SINE_LUT_QUARTER_WAVE_EN
    localparam logic [LUT_DEPTH-2:0] QW = (LUT_DEPTH - 1)'(1 << (LUT_DEPTH - 2));

    quadrant_t             quad;
    logic [LUT_DEPTH-2:0]  idx_w;
    logic [LUT_DEPTH-2:0]  ridx;
    logic                  neg;
    logic [DATA_WIDTH-1:0] rdata;

    assign quad  = quadrant_t'(address[LUT_DEPTH-1:LUT_DEPTH-2]);
    assign idx_w = {1'b0, address[LUT_DEPTH-3:0]};

    always_comb begin
        ridx = idx_w;
        neg  = 1'b0;
        case (quad)
            Q0: ridx = idx_w;
            Q1: ridx = QW - idx_w;
            Q2: begin
                ridx = idx_w;
                neg  = 1'b1;
            end
            Q3: begin
                ridx = QW - idx_w;
                neg  = 1'b1;
            end
            default: ridx = idx_w;
        endcase
    end

    sine_quarter_rom #(
        .DATA_WIDTH (DATA_WIDTH),
        .LUT_DEPTH  (LUT_DEPTH)
    ) u_rom (
        .idx  (ridx),
        .data (rdata)
    );

    assign sample = neg ? (DATA_WIDTH'(0) - rdata) : rdata;
`else
    localparam int N = 1 << LUT_DEPTH;

    logic [DATA_WIDTH-1:0] rom [N];

    for (genvar g = 0; g < N; g++) begin : g_rom
        localparam logic [DATA_WIDTH-1:0] E =
            DATA_WIDTH'(sine_entry(g, DATA_WIDTH, LUT_DEPTH));
        assign rom[g] = E;
    end

    assign sample = rom[address];
`endif

    always_comb begin
        value_d = value_q;
        if (en) begin
            value_d = sample;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: tb/tb_sine_lut.sv
// Directed vector bench for sine_lut at 16x256 and at the 8x8 minimum depth.
// Expected samples come from hand constants and a $sin reference model.
module tb_sine_lut;

    logic        clk;
    logic        arst;
    logic        en;
    logic [7:0]  address;
    logic [15:0] value;
    logic [2:0]  address_s;
    logic [7:0]  value_s;

    int total;
    int bad;

    sine_lut #(.DATA_WIDTH(16), .LUT_DEPTH(8)) dut (
        .clk     (clk),
        .arst    (arst),
        .en      (en),
        .address (address),
        .value   (value)
    );

    sine_lut #(.DATA_WIDTH(8), .LUT_DEPTH(3)) dut_s (
        .clk     (clk),
        .arst    (arst),
        .en      (en),
        .address (address_s),
        .value   (value_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [7:0]  addr;
        logic [15:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[10];
    logic [15:0] got[256];
    logic [7:0]  small_exp[8];

    function automatic int model(input int a, input int dw, input int ld);
        real amp;
        real v;
        amp = real'((1 << (dw - 1)) - 1);
        v   = amp * $sin(2.0 * 3.14159265358979323846 * real'(a) / real'(1 << ld));
        if (v >= 0.0) return int'($floor(v + 0.5));
        return -int'($floor(0.5 - v));
    endfunction

    task automatic check16(input string name, input logic [15:0] act,
                           input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] act,
                          input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic step(input logic e, input logic [7:0] a);
        @(negedge clk);
        en      = e;
        address = a;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        arst      = 1'b1;
        en        = 1'b0;
        address   = '0;
        address_s = '0;

        vecs[0] = '{1'b1, 8'd0,   16'h0000, "card_0"};
        vecs[1] = '{1'b1, 8'd64,  16'h7FFF, "card_64"};
        vecs[2] = '{1'b1, 8'd128, 16'h0000, "card_128"};
        vecs[3] = '{1'b1, 8'd192, 16'h8001, "card_192"};
        vecs[4] = '{1'b1, 8'd32,  16'h5A82, "oct_32"};
        vecs[5] = '{1'b1, 8'd96,  16'h5A82, "oct_96"};
        vecs[6] = '{1'b1, 8'd224, 16'hA57E, "oct_224"};
        vecs[7] = '{1'b0, 8'd64,  16'hA57E, "hold_en0"};
        vecs[8] = '{1'b1, 8'd64,  16'h7FFF, "load_en1"};
        vecs[9] = '{1'b0, 8'd192, 16'h7FFF, "hold_after"};

        small_exp = '{8'd0, 8'd90, 8'd127, 8'd90, 8'd0, 8'hA6, 8'h81, 8'hA6};

        #2;
        check16("reset_init", value, 16'h0000);
        @(negedge clk);
        arst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            step(vecs[i].en, vecs[i].addr);
            check16(vecs[i].name, value, vecs[i].exp);
        end

        // Asynchronous clear mid-stream, away from any clock edge.
        @(negedge clk);
        #2;
        arst = 1'b1;
        #1;
        check16("arst_async", value, 16'h0000);
        en      = 1'b1;
        address = 8'd64;
        @(posedge clk);
        #1;
        check16("arst_held_en", value, 16'h0000);
        @(negedge clk);
        arst = 1'b0;
        en   = 1'b0;
        @(posedge clk);
        #1;
        check16("post_rst_en0", value, 16'h0000);
        step(1'b1, 8'd64);
        check16("first_load", value, 16'h7FFF);

        // Full sweep with wrap back to address 0.
        for (int a = 0; a < 257; a++) begin
            step(1'b1, 8'(a % 256));
            check16($sformatf("sweep_%0d", a), value, 16'(model(a % 256, 16, 8)));
            if (a < 256) got[a] = value;
        end
        for (int a = 0; a < 128; a++) begin
            check16($sformatf("sym_neg_%0d", a), got[a + 128], 16'h0000 - got[a]);
            check16($sformatf("cos_%0d", a), got[a + 64], 16'(model(a + 64, 16, 8)));
        end

        // Minimum-depth instance.
        for (int a = 0; a < 8; a++) begin
            @(negedge clk);
            en        = 1'b1;
            address_s = 3'(a);
            @(posedge clk);
            #1;
            check8($sformatf("small_%0d", a), value_s, small_exp[a]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
